// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the sum_accumulator block-sum stage.
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Full-growth width: N samples of L bits need log2(N) extra bits.
  function automatic int acc_width(input int l, input int n);
    return l + $clog2(n);
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates N consecutive signed sums into a full-growth total on a valid/ready output.
// Optional window mean output out_avg is enabled by defining SUM_ACC_AVG_EN.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int L  = 4,
  parameter  int N  = 8,
  localparam int AW = acc_width(L, N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [L-1:0]  in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_acc
`ifdef SUM_ACC_AVG_EN
  ,
  output logic signed [L-1:0]  out_avg
`endif
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [AW-1:0]  out_acc_q, out_acc_d;

  logic                  transfer;
  logic signed [AW-1:0]  sum_ext;
  logic signed [AW-1:0]  sum_total;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state_q == ACCUM);
  assign transfer  = in_valid && in_ready;
  assign sum_ext   = AW'(in_sum);
  assign sum_total = acc_q + sum_ext;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;

    unique case (state_q)
      ACCUM: begin
        if (transfer) begin
          if (cnt_q == LAST) begin
            out_acc_d   = sum_total;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            acc_d = sum_total;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;

`ifdef SUM_ACC_AVG_EN
  logic signed [L-1:0] avg_q, avg_d;

  // Dropping the low log2(N) bits is an arithmetic shift: the mean floors toward -inf.
  always_comb begin
    avg_d = avg_q;
    if (state_q == ACCUM && transfer && cnt_q == LAST) begin
      avg_d = sum_total[AW-1:CW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_q <= '0;
    end else begin
      avg_q <= avg_d;
    end
  end

  assign out_avg = avg_q;
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator with L=4, N=4 (AW=6).
module tb_sum_accumulator;

  localparam int L  = 4;
  localparam int N  = 4;
  localparam int AW = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [L-1:0]  in_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_acc;
`ifdef SUM_ACC_AVG_EN
  logic signed [L-1:0]  out_avg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sum_accumulator #(.L(L), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc)
`ifdef SUM_ACC_AVG_EN
    ,
    .out_avg   (out_avg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_sum   = L'(v);
    tick();
    in_valid = 1'b0;
    in_sum   = 'x;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    check("no_valid_before_nth", int'(out_valid), 0);
    send(d);
  endtask

  task automatic check_result(input string tag, input int acc, input int avg);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_acc"}, int'(out_acc), acc);
    check({tag, "_ready_low"}, int'(in_ready), 0);
`ifdef SUM_ACC_AVG_EN
    check({tag, "_avg"}, int'(out_avg), avg);
`endif
  endtask

  task automatic drain(input string tag, input int acc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, int'(out_valid), 0);
    check({tag, "_drain_ready"}, int'(in_ready), 1);
    check({tag, "_drain_acc_kept"}, int'(out_acc), acc);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_acc", int'(out_acc), 0);
`ifdef SUM_ACC_AVG_EN
    check("rst_out_avg", int'(out_avg), 0);
`endif
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Basic window.
    send4(3, 2, 1, -1);
    check_result("w_basic", 5, 1);
    drain("w_basic", 5);

    // Most negative and most positive windows.
    send4(-8, -8, -8, -8);
    check_result("w_min", -32, -8);
    drain("w_min", -32);
    send4(7, 7, 7, 7);
    check_result("w_max", 28, 7);
    drain("w_max", 28);

    // Backpressure: result held for 5 cycles while junk is offered on the input.
    send4(1, 1, 1, 1);
    in_valid = 1'b1;
    in_sum   = 4'sd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_acc", int'(out_acc), 4);
      check("hold_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    drain("hold", 4);

    // Input gaps with out_ready held high throughout.
    out_ready = 1'b1;
    send(2);
    in_sum = 4'sd7;
    repeat (3) tick();
    check("gap_early_ready_ignored", int'(out_valid), 0);
    send(2);
    in_sum = -4'sd5;
    tick();
    send(2);
    send(2);
    check("gap_valid", int'(out_valid), 1);
    check("gap_acc", int'(out_acc), 8);
    tick();
    check("gap_hold_one_cycle", int'(out_valid), 0);
    check("gap_ready_back", int'(in_ready), 1);
    out_ready = 1'b0;

    // Reset mid-window discards partial data.
    send(5);
    send(5);
    rst_n = 1'b0;
    tick();
    check("midrst_ready", int'(in_ready), 0);
    check("midrst_acc", int'(out_acc), 0);
    rst_n = 1'b1;
    #1;
    send4(1, 1, 1, 1);
    check_result("w_after_rst", 4, 1);
    drain("w_after_rst", 4);

    // Floor behaviour of the mean.
    send4(-3, 0, 0, 0);
    check_result("w_floor", -3, -1);
    drain("w_floor", -3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the parameterized signed adder; consumes its L-bit signed sum stream.
- Accumulates N consecutive accepted sums into a full-growth signed result and presents it on a valid/ready output.
- Serves as the block-sum / averaging stage after the adder array.

Parameters:
- L, 4, width of incoming signed sum (matches the upstream adder's L).
- N, 8, samples per accumulation window; power of two, ≥2.
- AW (localparam), L+$clog2(N), accumulator/output width; full growth, cannot overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_sum is valid this cycle.
- in_ready  out  1  block accepts in_sum this cycle.
- in_sum  in  L  signed sum from the upstream adder.
- out_valid  out  1  out_acc holds a completed window result.
- out_ready  in  1  downstream accepts out_acc.
- out_acc  out  AW  signed window total.
- out_avg  out  L  signed window mean; present only with SUM_ACC_AVG_EN.

Behaviour:
- Reset: synchronous; rst_n=0 at a rising edge clears all state. Any partial window is discarded.
  - Reset values: state=ACCUM, acc=0, cnt=0, out_valid=0, out_acc=0, out_avg=0.
  - in_ready is 0 while rst_n=0. It is 1 in the first cycle after release.
- Input handshake: a sample transfers on a rising edge with in_valid&&in_ready.
  - in_sum is sign-extended to AW before adding.
  - in_ready is combinational from state only: 1 in ACCUM, 0 in HOLD.
- FSM has two states.
  - ACCUM, on transfer with cnt<N-1: acc+=sext(in_sum), cnt++.
  - ACCUM, on transfer with cnt==N-1: out_acc<=acc+sext(in_sum), acc<=0, cnt<=0, out_valid<=1, state->HOLD.
  - ACCUM with no transfer: state unchanged.
  - HOLD: out_acc and out_valid stay stable until accepted; in_ready=0.
  - HOLD, when out_valid&&out_ready at an edge: out_valid<=0, state->ACCUM. out_acc keeps its last value.
- Latency: out_valid rises 1 cycle after the N-th sample transfers.
  - Throughput: at most one window per N+1 cycles, since HOLD lasts at least 1 cycle.
- Boundaries:
  - in_valid deasserted mid-window: accumulation pauses, no loss.
  - out_ready high before out_valid: ignored.
  - out_ready held high continuously: HOLD lasts exactly 1 cycle.
  - cnt wraps to 0 only on window completion.
  - in_sum is ignored whenever in_ready=0.
- Arithmetic: two's complement, signed throughout.
  - Range is N·(−2^(L−1)) … N·(2^(L−1)−1), which fits AW exactly. No saturation is needed.

Optional Feature:
- Macro: SUM_ACC_AVG_EN.
- Defined:
  - Adds port out_avg[L-1:0].
  - out_avg is registered on the same edge as out_acc: out_avg = out_acc >>> $clog2(N).
  - This is an arithmetic shift, so it floors toward −∞.
  - Reset value 0; held with out_acc.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package sum_acc_pkg holds:
  - the state enum (ACCUM, HOLD);
  - a constant function for AW from L and N.
- No sub-module: the accumulator adder is inline, and the FSM is too small to split.

Test Plan (L=4, N=4, AW=6):
- Reset then continuous in_valid, samples 3,2,1,−1 -> out_valid=1 one cycle after the 4th sample; out_acc=5; out_avg=1 (with macro).
- Samples −8,−8,−8,−8 -> out_acc=−32 (6'b100000); out_avg=−8. Samples 7,7,7,7 -> out_acc=28, out_avg=7.
- Samples 1,1,1,1 with out_ready=0 for 5 cycles -> out_valid and out_acc=4 stable; in_ready=0 throughout. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- in_valid gaps: 2, idle 3 cycles, 2, idle, 2, 2 -> out_acc=8; samples presented during idle cycles are ignored.
- Reset mid-window after 2 accepted samples (5,5), then 1,1,1,1 -> out_acc=4; no contribution from pre-reset data.
- Samples −3,0,0,0 -> out_acc=−3, out_avg=−1 (floor check).
